tia_object_position_counter: RTL and testbench

Per-object horizontal position counter for the TIA core, and the consumer of the extra-clock strobes produced by the HMOVE motion logic. Advances once per visible color clock plus once per extra-clock strobe, and wraps every scan line. Emits a one-cycle start pulse at each copy position selected by NUSIZ for the graphics serializer. One instance per movable object (P0, P1, M0, M1, BL).

---
 rtl/tia_object_position_counter.sv | 137 +++++++++++++
 tb/tb_tia_object_position_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tia_object_position_counter.sv
// tia_object_position_counter
// Horizontal position counter for one movable TIA object (P0, P1, M0, M1, BL).
// The counter advances on each visible color clock and on each HMOVE extra-clock
// strobe. It wraps every scan line. A one-cycle start pulse is issued when the
// counter lands on a copy offset, and that pulse feeds the graphics serializer.
// Optional feature macro: TIA_POSITION_COPIES_EN
//   defined   : the full NUSIZ copy-offset decode is built (copies at 16/32/64).
//   undefined : only the main copy at offset 0 is built, and copy is tied to 0.
module tia_object_position_counter #(
  parameter int LINE_LEN   = 160,
  parameter int RESP_DELAY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hblank,
  input  logic       ec_bar,
  input  logic       resp,
  input  logic [2:0] nusiz,
  output logic [7:0] pos,
  output logic       start,
  output logic [1:0] copy
);

  localparam logic [7:0] LAST_POS = 8'(LINE_LEN - 1);
  localparam logic [7:0] RESP_POS = 8'(LINE_LEN - RESP_DELAY);

  logic [7:0] pos_q, pos_d;
  logic       start_q, start_d;
  logic       advance;
  logic [7:0] pos_inc;
  logic       hit;
  logic [1:0] hit_idx;

  // A visible clock and an extra clock in the same cycle produce a single advance.
  assign advance = ~hblank | ~ec_bar;
  assign pos_inc = (pos_q == LAST_POS) ? 8'd0 : pos_q + 8'd1;

`ifdef TIA_POSITION_COPIES_EN
  logic [1:0] copy_q, copy_d;

  // Decode the copy offsets of the current NUSIZ code against the incremented position.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    if (pos_inc == 8'd0) begin
      hit     = 1'b1;
      hit_idx = 2'd0;
    end else begin
      case (nusiz)
        3'b001: begin
          if (pos_inc == 8'd16) begin hit = 1'b1; hit_idx = 2'd1; end
        end
        3'b010: begin
          if (pos_inc == 8'd32) begin hit = 1'b1; hit_idx = 2'd1; end
        end
        3'b011: begin
          if (pos_inc == 8'd16) begin hit = 1'b1; hit_idx = 2'd1; end
          if (pos_inc == 8'd32) begin hit = 1'b1; hit_idx = 2'd2; end
        end
        3'b100: begin
          if (pos_inc == 8'd64) begin hit = 1'b1; hit_idx = 2'd1; end
        end
        3'b110: begin
          if (pos_inc == 8'd32) begin hit = 1'b1; hit_idx = 2'd1; end
          if (pos_inc == 8'd64) begin hit = 1'b1; hit_idx = 2'd2; end
        end
        default: begin
          hit     = 1'b0;
          hit_idx = 2'd0;
        end
      endcase
    end
  end

  // The copy index is loaded only with a start pulse (or cleared by RESP), so it stays valid for that pulse.
  always_comb begin
    copy_d = copy_q;
    if (resp) begin
      copy_d = 2'd0;
    end else if (advance && hit) begin
      copy_d = hit_idx;
    end
  end

  // Register for the copy index.
  always_ff @(posedge clk) begin
    if (reset) begin
      copy_q <= 2'd0;
    end else begin
      copy_q <= copy_d;
    end
  end

  assign copy = copy_q;
`else
  // Only the main copy exists. NUSIZ plays no part in this configuration.
  logic unused_nusiz;
  assign unused_nusiz = ^nusiz;

  always_comb begin
    hit     = (pos_inc == 8'd0);
    hit_idx = 2'd0;
  end

  logic [1:0] unused_hit_idx;
  assign unused_hit_idx = hit_idx;
  assign copy = 2'd0;
`endif

  // Next-state logic. RESP wins over an advance in the same cycle. A hold always drops start.
  always_comb begin
    pos_d   = pos_q;
    start_d = 1'b0;
    if (resp) begin
      pos_d   = RESP_POS;
      start_d = 1'b0;
    end else if (advance) begin
      pos_d   = pos_inc;
      start_d = hit;
    end
  end

  // Register for position and start. start is registered together with pos, so it lines up with the offset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q   <= 8'd0;
      start_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      start_q <= start_d;
    end
  end

  assign pos   = pos_q;
  assign start = start_q;

endmodule

// File: tb/tb_tia_object_position_counter.sv
// Testbench for tia_object_position_counter.
// Each stimulus step queues the response it expects. A monitor then compares the DUT
// outputs after every clock edge.
module tb_tia_object_position_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hblank = 1'b1;
  logic       ec_bar = 1'b1;
  logic       resp = 1'b0;
  logic [2:0] nusiz = 3'b000;
  logic [7:0] pos;
  logic       start;
  logic [1:0] copy;

  typedef struct {
    int    pos;
    bit    start;
    int    copy;
    bit    chk_copy;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  tia_object_position_counter #(.LINE_LEN(160), .RESP_DELAY(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .hblank (hblank),
    .ec_bar (ec_bar),
    .resp   (resp),
    .nusiz  (nusiz),
    .pos    (pos),
    .start  (start),
    .copy   (copy)
  );

  always #5 clk = ~clk;

  // Monitor: after each rising edge, pop one expected response and compare it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (pos !== 8'(e.pos) || start !== e.start || (e.chk_copy && copy !== 2'(e.copy))) begin
        failures++;
        $display("FAIL %s: pos=%0d start=%0b copy=%0d, expected pos=%0d start=%0b copy=%0d%s",
                 e.name, pos, start, copy, e.pos, e.start, e.copy, e.chk_copy ? "" : " (copy not checked)");
      end
    end
  end

  // Apply the current inputs for one clock and queue the expected post-edge outputs.
  task automatic step(input string nm, input int ep, input bit es, input int ecp, input bit cc);
    exp_t e;
    e.pos = ep; e.start = es; e.copy = ecp; e.chk_copy = cc; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  int p;
  int exp_copy;
  bit exp_start;

  initial begin
    // Reset
    reset = 1'b1; hblank = 1'b1; ec_bar = 1'b1; resp = 1'b0; nusiz = 3'b000;
    step("reset0", 0, 1'b0, 0, 1'b1);
    step("reset1", 0, 1'b0, 0, 1'b1);
    $display("reset: pos=%0d start=%0b copy=%0d", pos, start, copy);
    reset = 1'b0;

    // Free run for 330 visible clocks. Starts fall on cycles 160 and 320.
    hblank = 1'b0;
    for (int i = 1; i <= 330; i++) begin
      step("freerun", i % 160, (i == 160) || (i == 320), 0, (i == 160) || (i == 320));
    end
    $display("freerun: 330 clocks, pos=%0d", pos);

    // During hblank without strobes the counter is frozen at 10.
    hblank = 1'b1;
    for (int i = 0; i < 50; i++) step("hblank_hold", 10, 1'b0, 0, 1'b0);
    $display("hblank hold: pos=%0d", pos);

    // Five single-cycle extra clocks during hblank take 10 to 15.
    for (int k = 1; k <= 5; k++) begin
      ec_bar = 1'b0;
      step("ec_strobe", 10 + k, 1'b0, 0, 1'b0);
      ec_bar = 1'b1;
      step("ec_gap", 10 + k, 1'b0, 0, 1'b0);
    end
    $display("ec strobes: pos=%0d", pos);

    // After hblank falls, the next start arrives after 145 visible clocks.
    hblank = 1'b0;
    for (int i = 1; i <= 145; i++) begin
      step("shifted_start", (15 + i) % 160, i == 145, 0, i == 145);
    end
    $display("shifted start: pos=%0d start=%0b", pos, start);

    // A hold cycle right after a start drops start and keeps copy.
    hblank = 1'b1;
    step("hold_clears_start", 0, 1'b0, 0, 1'b1);
    hblank = 1'b0;

    // NUSIZ 011: with copies built, starts at 16/32/0 with copy 1/2/0.
    nusiz = 3'b011;
    for (int i = 1; i <= 160; i++) begin
      p = i % 160;
`ifdef TIA_POSITION_COPIES_EN
      exp_start = (p == 0) || (p == 16) || (p == 32);
      exp_copy  = (p == 16) ? 1 : (p == 32) ? 2 : 0;
`else
      exp_start = (p == 0);
      exp_copy  = 0;
`endif
      step("nusiz011", p, exp_start, exp_copy, exp_start);
    end
    $display("nusiz=011 line done: pos=%0d copy=%0d", pos, copy);

    // NUSIZ 110: with copies built, starts at 32/64/0 with copy 1/2/0.
    nusiz = 3'b110;
    for (int i = 1; i <= 160; i++) begin
      p = i % 160;
`ifdef TIA_POSITION_COPIES_EN
      exp_start = (p == 0) || (p == 32) || (p == 64);
      exp_copy  = (p == 32) ? 1 : (p == 64) ? 2 : 0;
`else
      exp_start = (p == 0);
      exp_copy  = 0;
`endif
      step("nusiz110", p, exp_start, exp_copy, exp_start);
    end
    $display("nusiz=110 line done: pos=%0d copy=%0d", pos, copy);

    // RESP at pos 50 while advancing: the counter goes to 156 and the advance is dropped.
    nusiz = 3'b000;
    for (int i = 1; i <= 50; i++) step("to_50", i, 1'b0, 0, 1'b0);
    resp = 1'b1;
    step("resp_at_50", 156, 1'b0, 0, 1'b1);
    resp = 1'b0;
    step("resp_d1", 157, 1'b0, 0, 1'b0);
    step("resp_d2", 158, 1'b0, 0, 1'b0);
    step("resp_d3", 159, 1'b0, 0, 1'b0);
    step("resp_d4_start", 0, 1'b1, 0, 1'b1);
    $display("resp at 50: start after 4 clocks pos=%0d start=%0b", pos, start);

    // RESP at pos 159 while advancing: there is no wrap start.
    for (int i = 1; i <= 159; i++) step("to_159", i, 1'b0, 0, 1'b0);
    resp = 1'b1;
    step("resp_at_159", 156, 1'b0, 0, 1'b1);
    resp = 1'b0;
    for (int i = 1; i <= 4; i++) step("resp159_run", (156 + i) % 160, i == 4, 0, i == 4);
    $display("resp at 159: pos=%0d start=%0b", pos, start);

    // RESP during hblank: the main copy comes RESP_DELAY visible clocks after hblank falls.
    hblank = 1'b1;
    resp = 1'b1;
    step("resp_hblank", 156, 1'b0, 0, 1'b1);
    resp = 1'b0;
    step("resp_hblank_hold", 156, 1'b0, 0, 1'b0);
    hblank = 1'b0;
    for (int i = 1; i <= 4; i++) step("resp_hblank_run", (156 + i) % 160, i == 4, 0, i == 4);

    // Reset mid-line, asserted together with RESP and an extra clock.
    for (int i = 1; i <= 20; i++) step("to_20", i, 1'b0, 0, 1'b0);
    reset = 1'b1; resp = 1'b1; ec_bar = 1'b0; hblank = 1'b1;
    step("reset_dominates", 0, 1'b0, 0, 1'b1);
    reset = 1'b0; resp = 1'b0; ec_bar = 1'b1; hblank = 1'b0;
    step("post_reset_adv", 1, 1'b0, 0, 1'b0);
    $display("reset dominance: pos=%0d start=%0b", pos, start);

    // Every queued expectation has to be consumed by this point.
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
